// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiters: response FIFO sizing and the
// round-robin scan used by both the read arbiter and the write-side scheduler.
package sram_arb_pkg;

    localparam int RSP_FIFO_DEPTH = 2;
    localparam int RR_MAX         = 8;
    localparam int RR_IDX_W       = 3;

    // First set bit of vec scanning upward from ptr+1, wrapping at n; returns ptr if none.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_IDX_W-1:0] ptr,
        input logic [RR_MAX-1:0]   vec,
        input int                  n
    );
        logic [RR_IDX_W-1:0] idx;
        logic                found;
        int                  k;
        idx   = ptr;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            k = (int'(ptr) + i) % n;
            if (i <= n && !found && vec[k[RR_IDX_W-1:0]]) begin
                idx   = k[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sram_rd_arbiter_rr.sv
// Combinational round-robin grant; the priority pointer lives in the parent.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [RR_IDX_W-1:0] idx_full;

    always_comb begin
        idx_full = rr_next(RR_IDX_W'(ptr), RR_MAX'(req), N);
        gnt_idx  = idx_full[W-1:0];
        gnt      = '0;
        if (en && (|req)) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_rd_arbiter.sv
// Round-robin sharing of a 1w1r SRAM read port; fixed 2-cycle latency with
// in-order tagged responses held in a 2-entry output FIFO.
module sram_rd_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 1024,
    parameter int WADDR = $clog2(DEPTH),
    parameter int WWORD = 96,
    parameter int WID   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WADDR-1:0] req_addr,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WID-1:0]        rsp_id,
    output logic [WWORD-1:0]      rsp_data,
    input  logic                  rsp_ready,
    output logic                  sram_cena,
    output logic [WADDR-1:0]      sram_aa,
    input  logic [WWORD-1:0]      sram_qa
);

    logic [WID-1:0]   ptr_q, ptr_d;
    logic             inflight_q, inflight_d;
    logic [WID-1:0]   id_s1_q, id_s1_d;
    logic [WADDR-1:0] aa_q, aa_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WID-1:0]   head_id_q, head_id_d, tail_id_q, tail_id_d;
    logic [WWORD-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;

    logic             deq;
    logic             enq;
    logic [2:0]       credit_used;
    logic             can_issue;
    logic [NREQ-1:0]  gnt;
    logic [WID-1:0]   gnt_idx;
    logic             any_gnt;

    assign deq         = rsp_valid & rsp_ready;
    assign enq         = inflight_q;
    assign credit_used = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, deq};
    // Grants are held off while reset is asserted so the port stays idle.
    assign can_issue   = rstn && (credit_used < 3'(RSP_FIFO_DEPTH));

    rr_arbiter #(.N(NREQ), .W(WID)) u_rr (
        .req     (req_valid),
        .en      (can_issue),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt   = |gnt;
    assign req_ready = gnt;
    assign sram_cena = ~any_gnt;
    assign sram_aa   = aa_d;

    always_comb begin
        aa_d = aa_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                aa_d = req_addr[i*WADDR +: WADDR];
            end
        end
        ptr_d      = any_gnt ? gnt_idx : ptr_q;
        id_s1_d    = any_gnt ? gnt_idx : id_s1_q;
        inflight_d = any_gnt;
    end

    // Head slot always drives the response outputs; the tail only fills at count 1.
    always_comb begin
        cnt_d       = cnt_q;
        head_id_d   = head_id_q;
        head_data_d = head_data_q;
        tail_id_d   = tail_id_q;
        tail_data_d = tail_data_q;
        case ({enq, deq})
            2'b11: begin
                head_id_d   = id_s1_q;
                head_data_d = sram_qa;
            end
            2'b01: begin
                head_id_d   = tail_id_q;
                head_data_d = tail_data_q;
                cnt_d       = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_id_d   = id_s1_q;
                    head_data_d = sram_qa;
                end else begin
                    tail_id_d   = id_s1_q;
                    tail_data_d = sram_qa;
                end
                cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q       <= WID'(NREQ - 1);
            inflight_q  <= 1'b0;
            id_s1_q     <= '0;
            aa_q        <= '0;
            cnt_q       <= 2'd0;
            head_id_q   <= '0;
            head_data_q <= '0;
            tail_id_q   <= '0;
            tail_data_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            inflight_q  <= inflight_d;
            id_s1_q     <= id_s1_d;
            aa_q        <= aa_d;
            cnt_q       <= cnt_d;
            head_id_q   <= head_id_d;
            head_data_q <= head_data_d;
            tail_id_q   <= tail_id_d;
            tail_data_q <= tail_data_d;
        end
    end

    assign rsp_valid = (cnt_q != 2'd0);
    assign rsp_id    = head_id_q;
    assign rsp_data  = head_data_q;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed bench for sram_rd_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_sram_rd_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 1024;
    localparam int WADDR = 10;
    localparam int WWORD = 96;
    localparam int WID   = 2;

    logic                  clk;
    logic                  rstn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WADDR-1:0] req_addr;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [WID-1:0]        rsp_id;
    logic [WWORD-1:0]      rsp_data;
    logic                  rsp_ready;
    logic                  sram_cena;
    logic [WADDR-1:0]      sram_aa;
    logic [WWORD-1:0]      sram_qa;

    logic [WWORD-1:0] mem [0:DEPTH-1];

    int checks;
    int failures;

    sram_rd_arbiter #(
        .NREQ(NREQ), .DEPTH(DEPTH), .WADDR(WADDR), .WWORD(WWORD), .WID(WID)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .sram_cena (sram_cena),
        .sram_aa   (sram_aa),
        .sram_qa   (sram_qa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cena) sram_qa <= mem[sram_aa];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_addrs(input int base);
        for (int i = 0; i < NREQ; i++) req_addr[i*WADDR +: WADDR] = WADDR'(base + i);
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1; set_addrs(16);
        repeat (3) sample();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (sram_cena !== 1'b1) begin failures++; $display("FAIL reset_cena got=%b exp=1", sram_cena); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (sram_aa !== 10'd0) begin failures++; $display("FAIL reset_aa got=%h exp=000", sram_aa); end
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 96'd0) begin failures++; $display("FAIL reset_rsp_regs id=%0d data=%h exp=0/0", rsp_id, rsp_data); end
        step(); rstn = 1'b1;
        sample();
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b exp=0001", req_ready); end
        checks++; if (sram_aa !== 10'h010 || sram_cena !== 1'b0) begin failures++; $display("FAIL first_aa aa=%h cena=%b exp=010/0", sram_aa, sram_cena); end
        $display("reset: released, first grant req_ready=%b", req_ready);
    endtask

    // Continues from the first post-reset cycle; all four requesters valid.
    task automatic test_round_robin();
        logic [3:0] exp_g;
        int eid;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cyc != 0) begin
                step();
                if (cyc == 12) req_valid = 4'h0;
                sample();
            end
            exp_g = (cyc < 12) ? 4'(1 << (cyc % 4)) : 4'b0000;
            checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_g); end
            if (cyc >= 2 && cyc < 14) begin
                eid = (cyc - 2) % 4;
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== WID'(eid) || rsp_data !== mem[16 + eid]) begin
                    failures++; $display("FAIL rr_rsp cyc=%0d v=%b id=%0d data=%h exp v=1 id=%0d data=%h", cyc, rsp_valid, rsp_id, rsp_data, eid, mem[16 + eid]);
                end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_idle cyc=%0d rsp_valid=%b exp=0", cyc, rsp_valid); end
            end
            $display("rr cyc=%0d req_ready=%b rsp_valid=%b rsp_id=%0d", cyc, req_ready, rsp_valid, rsp_id);
        end
    endtask

    task automatic test_latency();
        step(); req_valid = 4'b0100; req_addr[2*WADDR +: WADDR] = 10'h005;
        sample();
        checks++; if (req_ready !== 4'b0100 || sram_aa !== 10'h005 || sram_cena !== 1'b0) begin
            failures++; $display("FAIL lat_issue rdy=%b aa=%h cena=%b exp 0100/005/0", req_ready, sram_aa, sram_cena);
        end
        step(); req_valid = 4'b0000;
        sample();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lat_t1 rsp_valid=%b exp=0", rsp_valid); end
        checks++; if (sram_cena !== 1'b1 || sram_aa !== 10'h005) begin failures++; $display("FAIL aa_hold cena=%b aa=%h exp 1/005", sram_cena, sram_aa); end
        step(); sample();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 96'hA5) begin
            failures++; $display("FAIL lat_t2 v=%b id=%0d data=%h exp 1/2/a5", rsp_valid, rsp_id, rsp_data);
        end
        $display("latency: rsp_valid=%b rsp_id=%0d rsp_data=%h", rsp_valid, rsp_id, rsp_data);
        step(); sample();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lat_t3 rsp_valid=%b exp=0", rsp_valid); end
    endtask

    // Pointer is 2 on entry, so the first two grants go to 3 then 0.
    task automatic test_backpressure();
        logic [3:0] exp_g [0:10];
        int         exp_id [0:10];
        exp_g  = '{4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0100, 4'b0, 4'b0, 4'b0};
        exp_id = '{-1, -1, 3, 3, 3, 3, 3, 0, 1, 2, -1};
        for (int cyc = 0; cyc < 11; cyc++) begin
            step();
            if (cyc == 0) begin rsp_ready = 1'b0; req_valid = 4'hF; set_addrs(32); end
            if (cyc == 6) rsp_ready = 1'b1;
            if (cyc == 8) req_valid = 4'h0;
            sample();
            checks++; if (req_ready !== exp_g[cyc] || sram_cena !== (exp_g[cyc] == 4'b0)) begin
                failures++; $display("FAIL bp_grant cyc=%0d got=%b cena=%b exp=%b", cyc, req_ready, sram_cena, exp_g[cyc]);
            end
            if (exp_id[cyc] >= 0) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== WID'(exp_id[cyc]) || rsp_data !== mem[32 + exp_id[cyc]]) begin
                    failures++; $display("FAIL bp_rsp cyc=%0d v=%b id=%0d data=%h exp id=%0d data=%h", cyc, rsp_valid, rsp_id, rsp_data, exp_id[cyc], mem[32 + exp_id[cyc]]);
                end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_idle cyc=%0d rsp_valid=%b exp=0", cyc, rsp_valid); end
            end
            $display("bp cyc=%0d req_ready=%b rsp_valid=%b rsp_id=%0d rsp_ready=%b", cyc, req_ready, rsp_valid, rsp_id, rsp_ready);
        end
    endtask

    task automatic test_sparse();
        logic [3:0] vin   [0:6];
        logic [3:0] exp_g [0:6];
        int         exp_id [0:6];
        vin    = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0, 4'b0, 4'b0};
        exp_g  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0, 4'b0, 4'b0};
        exp_id = '{-1, -1, 1, 3, 1, 3, -1};
        set_addrs(48);
        for (int cyc = 0; cyc < 7; cyc++) begin
            step(); req_valid = vin[cyc];
            sample();
            checks++; if (req_ready !== exp_g[cyc]) begin failures++; $display("FAIL sparse_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_g[cyc]); end
            if (exp_id[cyc] >= 0) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== WID'(exp_id[cyc]) || rsp_data !== mem[48 + exp_id[cyc]]) begin
                    failures++; $display("FAIL sparse_rsp cyc=%0d v=%b id=%0d exp=%0d", cyc, rsp_valid, rsp_id, exp_id[cyc]);
                end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sparse_idle cyc=%0d rsp_valid=%b exp=0", cyc, rsp_valid); end
            end
            $display("sparse cyc=%0d req_ready=%b rsp_valid=%b rsp_id=%0d", cyc, req_ready, rsp_valid, rsp_id);
        end
    endtask

    // Pointer is 3 on entry; requester 0 alone fills one FIFO slot plus one in flight.
    task automatic test_async_reset();
        step(); rsp_ready = 1'b0; req_valid = 4'b0001; set_addrs(64);
        sample();
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL ar_g0 got=%b exp=0001", req_ready); end
        step(); sample();
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL ar_g1 got=%b exp=0001", req_ready); end
        step(); sample();
        checks++; if (req_ready !== 4'b0000 || sram_cena !== 1'b1 || rsp_valid !== 1'b1) begin
            failures++; $display("FAIL ar_full rdy=%b cena=%b v=%b exp 0000/1/1", req_ready, sram_cena, rsp_valid);
        end
        #2 rstn = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || sram_cena !== 1'b1 || sram_aa !== 10'd0) begin
            failures++; $display("FAIL ar_assert v=%b rdy=%b cena=%b aa=%h exp 0/0000/1/000", rsp_valid, req_ready, sram_cena, sram_aa);
        end
        $display("async reset: rsp_valid=%b req_ready=%b", rsp_valid, req_ready);
        step(); step();
        rstn = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0000;
        for (int cyc = 0; cyc < 5; cyc++) begin
            sample();
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ar_stale cyc=%0d rsp_valid=%b exp=0", cyc, rsp_valid); end
            step();
        end
        req_valid = 4'hF;
        sample();
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL ar_ptr got=%b exp=0001", req_ready); end
        step(); req_valid = 4'h0;
        repeat (3) step();
    endtask

    initial begin
        checks = 0; failures = 0;
        sram_qa = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = {32'h5A5A0000 ^ 32'(i), 32'(i * 3), 32'hC0FFEE00 | 32'(i)};
        end
        mem[5] = 96'hA5;
        req_addr = '0;
        test_reset();
        test_round_robin();
        test_latency();
        test_backpressure();
        test_sparse();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
